fu_alu_issue: RTL and testbench

- Dataflow issue/collect stage for the 64-bit integer ALU in a RipTide processing element; it is the producer side of the ALU operand interface and the consumer side of its result interface.
- Accepts operand tokens A and B over valid/ready channels and holds a configured opcode and optional constant B.
- Fires the ALU when its operands are present, and emits each result with the packed flags as a token on a valid/ready output through a 2-entry FIFO.
- Sustains one fire per cycle.

---
 rtl/fu_pkg.sv | 23 ++
 rtl/fu_alu_issue_if.sv | 32 +++
 rtl/fu_alu.sv | 41 ++++
 rtl/fu_alu_issue.sv | 138 +++++++++++++
 tb/tb_fu_alu_issue.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_pkg.sv
// Shared types for the RipTide integer ALU functional unit: opcodes, packed
// result flags and the fixed datapath width.
package fu_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    OP_PASSB = 3'b000,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic carry_out;
  } alu_flags_t;

endpackage

// File: rtl/fu_alu_issue_if.sv
// Token channels of the ALU issue stage: operand A, operand B and the result
// stream. The master side is the surrounding fabric, the slave side the stage.
interface fu_alu_issue_if
  import fu_pkg::*;
#(
  parameter int W = DATA_W
);

  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_ready;

  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_ready;

  logic         out_valid;
  logic [W-1:0] out_data;
  alu_flags_t   out_flags;
  logic         out_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/fu_alu.sv
// Combinational 64-bit integer ALU; subtraction reuses the adder as A + ~B + 1
// so carry and overflow come out of the same extended sum.
module fu_alu
  import fu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        cntrl,
  output logic [DATA_W-1:0] result,
  output alu_flags_t        flags
);

  logic              is_sub;
  logic              is_arith;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  always_comb begin
    is_sub   = (cntrl == OP_SUB);
    is_arith = (cntrl == OP_ADD) || is_sub;
    b_eff    = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

    result = '0;
    case (cntrl)
      OP_PASSB:       result = b;
      OP_ADD, OP_SUB: result = sum[DATA_W-1:0];
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      default:        result = '0;
    endcase

    flags.negative  = result[DATA_W-1];
    flags.zero      = (result == '0);
    flags.overflow  = is_arith && (a[DATA_W-1] == b_eff[DATA_W-1])
                               && (sum[DATA_W-1] != a[DATA_W-1]);
    flags.carry_out = is_arith && sum[DATA_W];
  end

endmodule

// File: rtl/fu_alu_issue.sv
// Dataflow issue/collect stage around fu_alu: buffers one A and one B token,
// fires when operands and output space are present, queues results in a 2-deep FIFO.
module fu_alu_issue
  import fu_pkg::*;
#(
  parameter int W         = DATA_W,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_op,
  input  logic             cfg_const_en,
  input  logic [W-1:0]     cfg_const,
  output logic             cfg_busy,
  fu_alu_issue_if.slave    io,
  output logic [CNT_W-1:0] fire_cnt
);

  logic [2:0]   op_q;
  logic         const_en_q;
  logic [W-1:0] const_q;

  logic         a_full, b_full;
  logic [W-1:0] a_buf, b_buf;

  logic [1:0]   out_count;
  logic [W-1:0] fifo_data  [OUT_DEPTH];
  alu_flags_t   fifo_flags [OUT_DEPTH];

  logic         fire, b_used, a_hs, b_hs, pop;
  logic [W-1:0] alu_b, alu_result;
  alu_flags_t   alu_flags;

  // Fire depends only on registered state, so out_ready never reaches a_ready/b_ready.
  assign fire   = a_full && (b_full || const_en_q) && (out_count != 2'(OUT_DEPTH));
  assign b_used = fire && !const_en_q;

  assign io.a_ready = !a_full || fire;
  assign io.b_ready = !const_en_q && (!b_full || b_used);
  assign a_hs       = io.a_valid && io.a_ready;
  assign b_hs       = io.b_valid && io.b_ready;
  assign pop        = io.out_valid && io.out_ready;

  assign cfg_busy     = a_full || b_full || (out_count != 2'd0);
  assign io.out_valid = (out_count != 2'd0);
  assign io.out_data  = fifo_data[0];
  assign io.out_flags = fifo_flags[0];

  assign alu_b = const_en_q ? const_q : b_buf;

  fu_alu u_alu (
    .a      (a_buf),
    .b      (alu_b),
    .cntrl  (op_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 3'b000;
      const_en_q <= 1'b0;
      const_q    <= '0;
    end else if (cfg_we && !cfg_busy) begin
      op_q       <= cfg_op;
      const_en_q <= cfg_const_en;
      const_q    <= cfg_const;
    end
  end

  // A freshly accepted token takes priority over emptying the buffer on fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_buf  <= '0;
      b_buf  <= '0;
    end else begin
      if (a_hs) begin
        a_buf  <= io.a_data;
        a_full <= 1'b1;
      end else if (fire) begin
        a_full <= 1'b0;
      end
      if (b_hs) begin
        b_buf  <= io.b_data;
        b_full <= 1'b1;
      end else if (b_used) begin
        b_full <= 1'b0;
      end
    end
  end

  // Entry 0 is always the head; a push together with a pop can only occur at count 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count     <= 2'd0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_flags[0] <= '0;
      fifo_flags[1] <= '0;
    end else begin
      case ({fire, pop})
        2'b10: begin
          if (out_count == 2'd0) begin
            fifo_data[0]  <= alu_result;
            fifo_flags[0] <= alu_flags;
          end else begin
            fifo_data[1]  <= alu_result;
            fifo_flags[1] <= alu_flags;
          end
          out_count <= out_count + 2'd1;
        end
        2'b01: begin
          fifo_data[0]  <= fifo_data[1];
          fifo_flags[0] <= fifo_flags[1];
          out_count     <= out_count - 2'd1;
        end
        2'b11: begin
          fifo_data[0]  <= alu_result;
          fifo_flags[0] <= alu_flags;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_cnt <= '0;
    end else if (fire) begin
      fire_cnt <= fire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fu_alu_issue.sv
// Directed bench for fu_alu_issue: a vector table of single operations plus
// hand-written sequences for backpressure, constant mode, config gating and reset.
module tb_fu_alu_issue;
  import fu_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_op;
  logic        cfg_const_en;
  logic [63:0] cfg_const;
  logic        cfg_busy;
  logic [31:0] fire_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int res_cyc = 0;
  int exp_fires = 0;

  vec_t        vecs [11];
  logic [63:0] bp_a [4];
  logic [63:0] bp_b [4];
  logic [63:0] bp_d [4];
  logic [3:0]  bp_f [4];

  fu_alu_issue_if #(.W(64)) io ();

  fu_alu_issue #(.W(64), .OUT_DEPTH(2), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_op       (cfg_op),
    .cfg_const_en (cfg_const_en),
    .cfg_const    (cfg_const),
    .cfg_busy     (cfg_busy),
    .io           (io),
    .fire_cnt     (fire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic configure(input logic [2:0] op, input logic cen, input logic [63:0] cval);
    cfg_we       = 1'b1;
    cfg_op       = op;
    cfg_const_en = cen;
    cfg_const    = cval;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the last handshake edge.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic use_a, input logic use_b);
    logic ta, tb;
    int   t;
    io.a_valid = use_a;
    io.a_data  = a;
    io.b_valid = use_b;
    io.b_data  = b;
    t = 0;
    while ((io.a_valid || io.b_valid) && t < 50) begin
      ta = io.a_valid && io.a_ready;
      tb = io.b_valid && io.b_ready;
      if (ta || tb) hs_cyc = cyc;
      @(negedge clk);
      t++;
      if (ta) io.a_valid = 1'b0;
      if (tb) io.b_valid = 1'b0;
    end
    if (io.a_valid || io.b_valid) begin
      timeoutFail("operand_handshake");
      io.a_valid = 1'b0;
      io.b_valid = 1'b0;
    end
  endtask

  task automatic waitResult(input string name, input logic [63:0] exp_d, input logic [3:0] exp_f);
    int t;
    t = 0;
    while (!io.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!io.out_valid) begin
      timeoutFail(name);
    end else begin
      res_cyc = cyc;
      checkOutput({name, "_data"}, io.out_data, exp_d);
      checkOutput({name, "_flags"}, {60'b0, io.out_flags}, {60'b0, exp_f});
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = '{OP_ADD,   64'd5,                   64'd7,                   64'd12,                  4'b0000};
    vecs[1]  = '{OP_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                   64'h8000_0000_0000_0000, 4'b1010};
    vecs[2]  = '{OP_SUB,   64'd3,                   64'd3,                   64'd0,                   4'b0101};
    vecs[3]  = '{OP_SUB,   64'd0,                   64'd1,                   64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[4]  = '{OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   64'd0,                   4'b0101};
    vecs[5]  = '{OP_AND,   64'hF0F0,                64'hFF00,                64'hF000,                4'b0000};
    vecs[6]  = '{OP_OR,    64'h0F,                  64'hF0,                  64'hFF,                  4'b0000};
    vecs[7]  = '{OP_XOR,   64'hAAAA,                64'hAAAA,                64'd0,                   4'b0100};
    vecs[8]  = '{OP_PASSB, 64'd9,                   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b1000};
    vecs[9]  = '{3'b111,   64'd5,                   64'd6,                   64'd0,                   4'b0100};
    vecs[10] = '{3'b001,   64'd5,                   64'd6,                   64'd0,                   4'b0100};

    bp_a = '{64'h1,  64'hF0, 64'hAA, 64'h100};
    bp_b = '{64'h3,  64'h0F, 64'hAA, 64'h1};
    bp_d = '{64'h2,  64'hFF, 64'h0,  64'h101};
    bp_f = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};

    rst_n        = 1'b0;
    cfg_we       = 1'b0;
    cfg_op       = 3'b000;
    cfg_const_en = 1'b0;
    cfg_const    = '0;
    io.a_valid   = 1'b0;
    io.a_data    = '0;
    io.b_valid   = 1'b0;
    io.b_data    = '0;
    io.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", {63'b0, io.out_valid}, 64'd0);
    checkOutput("rst_out_data", io.out_data, 64'd0);
    checkOutput("rst_out_flags", {60'b0, io.out_flags}, 64'd0);
    checkOutput("rst_fire_cnt", {32'b0, fire_cnt}, 64'd0);
    checkOutput("rst_a_ready", {63'b0, io.a_ready}, 64'd1);
    checkOutput("rst_b_ready", {63'b0, io.b_ready}, 64'd1);
    checkOutput("rst_cfg_busy", {63'b0, cfg_busy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      configure(vecs[i].op, 1'b0, 64'd0);
      applyStimulus(vecs[i].a, vecs[i].b, 1'b1, 1'b1);
      exp_fires++;
      waitResult($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_flags);
      checkOutput($sformatf("vec%0d_latency", i), 64'(res_cyc - hs_cyc), 64'd2);
      checkOutput($sformatf("vec%0d_fire_cnt", i), {32'b0, fire_cnt}, 64'(exp_fires));
    end

    $display("[TB] backpressure with out_ready low");
    configure(OP_XOR, 1'b0, 64'd0);
    io.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(bp_a[i], bp_b[i], 1'b1, 1'b1);
    checkOutput("bp_a_ready", {63'b0, io.a_ready}, 64'd0);
    checkOutput("bp_b_ready", {63'b0, io.b_ready}, 64'd0);
    checkOutput("bp_out_valid", {63'b0, io.out_valid}, 64'd1);
    checkOutput("bp_cfg_busy", {63'b0, cfg_busy}, 64'd1);
    checkOutput("bp_fire_cnt", {32'b0, fire_cnt}, 64'(exp_fires + 2));
    checkOutput("bp_head_held", io.out_data, bp_d[0]);
    fork
      applyStimulus(bp_a[3], bp_b[3], 1'b1, 1'b1);
      begin
        int k, t;
        k = 0;
        t = 0;
        io.out_ready = 1'b1;
        while (k < 4 && t < 40) begin
          if (io.out_valid) begin
            checkOutput($sformatf("bp_res%0d_data", k), io.out_data, bp_d[k]);
            checkOutput($sformatf("bp_res%0d_flags", k), {60'b0, io.out_flags}, {60'b0, bp_f[k]});
            k++;
          end
          @(negedge clk);
          t++;
        end
        if (k < 4) timeoutFail("bp_drain");
      end
    join
    exp_fires += 4;
    repeat (2) @(negedge clk);
    checkOutput("bp_no_duplicate", {63'b0, io.out_valid}, 64'd0);
    checkOutput("bp_fire_cnt_end", {32'b0, fire_cnt}, 64'(exp_fires));

    $display("[TB] constant operand mode");
    configure(OP_AND, 1'b1, 64'hFF);
    checkOutput("const_b_ready0", {63'b0, io.b_ready}, 64'd0);
    applyStimulus(64'h1234, 64'd0, 1'b1, 1'b0);
    checkOutput("const_b_ready1", {63'b0, io.b_ready}, 64'd0);
    waitResult("const0", 64'h34, 4'b0000);
    applyStimulus(64'hF0F0, 64'd0, 1'b1, 1'b0);
    checkOutput("const_b_ready2", {63'b0, io.b_ready}, 64'd0);
    waitResult("const1", 64'hF0, 4'b0000);
    exp_fires += 2;
    configure(OP_ADD, 1'b0, 64'd0);
    checkOutput("const_off_b_ready", {63'b0, io.b_ready}, 64'd1);
    checkOutput("const_off_busy", {63'b0, cfg_busy}, 64'd0);

    $display("[TB] config write while busy");
    applyStimulus(64'd10, 64'd0, 1'b1, 1'b0);
    checkOutput("busy_held_a", {63'b0, cfg_busy}, 64'd1);
    configure(OP_SUB, 1'b0, 64'd0);
    applyStimulus(64'd0, 64'd3, 1'b0, 1'b1);
    waitResult("busy_old_op", 64'd13, 4'b0000);
    checkOutput("idle_busy", {63'b0, cfg_busy}, 64'd0);
    configure(OP_SUB, 1'b0, 64'd0);
    applyStimulus(64'd10, 64'd3, 1'b1, 1'b1);
    waitResult("idle_new_op", 64'd7, 4'b0001);
    exp_fires += 2;
    checkOutput("busy_fire_cnt", {32'b0, fire_cnt}, 64'(exp_fires));

    $display("[TB] reset mid-stream");
    configure(OP_ADD, 1'b0, 64'd0);
    io.out_ready = 1'b0;
    applyStimulus(64'd1, 64'd2, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("pre_rst_valid", {63'b0, io.out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {63'b0, io.out_valid}, 64'd0);
    checkOutput("mid_rst_fire_cnt", {32'b0, fire_cnt}, 64'd0);
    checkOutput("mid_rst_a_ready", {63'b0, io.a_ready}, 64'd1);
    checkOutput("mid_rst_busy", {63'b0, cfg_busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    @(negedge clk);
    configure(OP_ADD, 1'b0, 64'd0);
    applyStimulus(64'd1, 64'd1, 1'b1, 1'b1);
    waitResult("post_rst_add", 64'd2, 4'b0000);
    checkOutput("post_rst_fire_cnt", {32'b0, fire_cnt}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
